// File: rtl/key_expansion_inv.sv
// Reverse AES-256 key schedule: loaded with K[NUM_KEYS-2] and K[NUM_KEYS-1], it regenerates
// the schedule backwards and hands out K[NUM_KEYS-1] down to K[0] over a valid/ready handshake.
module key_expansion_inv #(
  parameter int unsigned NUM_KEYS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] key_lo,
  input  logic [127:0] key_hi,
  output logic [127:0] key_out,
  output logic [3:0]   key_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         key_last
);

  localparam int unsigned KEY_W = 128;
  localparam int unsigned WIN_W = 2 * KEY_W;
  localparam int unsigned IDX_W = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [IDX_W-1:0] R_INIT   = IDX_W'(NUM_KEYS - 2);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NUM_KEYS - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h01;
      3'd1:    return 8'h02;
      3'd2:    return 8'h04;
      3'd3:    return 8'h08;
      3'd4:    return 8'h10;
      3'd5:    return 8'h20;
      3'd6:    return 8'h40;
      default: return 8'h80;
    endcase
  endfunction

  logic [0:0]       state, state_d;
  logic [WIN_W-1:0] win, win_d, step_win;
  logic [IDX_W-1:0] r, r_d, idx, idx_d, s;
  logic [31:0]      cw [8];
  logic [31:0]      f_val;
  logic             out_valid_d;
  logic [KEY_W-1:0] out_key_d;

  // Backward step: rebuild K[r-1] from K[r] (W0..3) and K[r+1] (W4..7).
  always_comb begin
    for (int j = 0; j < 8; j++) cw[j] = win[WIN_W-1-32*j -: 32];
    s = r - IDX_W'(1);
    if (s[0]) f_val = sub_word(cw[3]);
    else      f_val = sub_word({cw[3][23:0], cw[3][31:24]}) ^ {rcon(s[3:1]), 24'h0};
    step_win = {cw[4] ^ f_val, cw[5] ^ cw[4], cw[6] ^ cw[5], cw[7] ^ cw[6],
                cw[0], cw[1], cw[2], cw[3]};
  end

  // Next-state logic; load wins over any accept.
  always_comb begin
    state_d = state;
    win_d   = win;
    r_d     = r;
    idx_d   = idx;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_d = S_EMIT;
          win_d   = {key_lo, key_hi};
          r_d     = R_INIT;
          idx_d   = IDX_INIT;
        end
      end
      S_EMIT: begin
        if (load) begin
          win_d = {key_lo, key_hi};
          r_d   = R_INIT;
          idx_d = IDX_INIT;
        end else if (key_valid && key_ready) begin
          if (idx == r + IDX_W'(1)) begin
            idx_d = r;
          end else if (idx == r && r != '0) begin
            win_d = step_win;
            r_d   = r - IDX_W'(1);
            idx_d = r - IDX_W'(1);
          end else if (idx == '0) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_EMIT);
    out_key_d   = (idx_d == r_d + IDX_W'(1)) ? win_d[KEY_W-1:0] : win_d[WIN_W-1:KEY_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      win       <= '0;
      r         <= '0;
      idx       <= '0;
      key_valid <= 1'b0;
      key_out   <= '0;
      key_idx   <= '0;
      key_last  <= 1'b0;
    end else begin
      state     <= state_d;
      win       <= win_d;
      r         <= r_d;
      idx       <= idx_d;
      key_valid <= out_valid_d;
      key_out   <= out_valid_d ? out_key_d : '0;
      key_idx   <= out_valid_d ? idx_d : '0;
      key_last  <= out_valid_d && (idx_d == '0);
    end
  end

endmodule

// File: doc/key_expansion_inv.md
Name: key_expansion_inv

Overview:
- Reverse AES-256 key schedule for the decrypt path.
- Loaded with the last two 128-bit round keys of a schedule, it regenerates the schedule backwards and emits round keys in descending order, K[NUM_KEYS-1] down to K[0], one per accepted handshake.
- It is the other direction of the forward key expander: the inverse-cipher round pipeline consumes keys in reverse order without storing a full schedule.

Parameters:
- NUM_KEYS, 10, number of 128-bit round keys in the schedule (legal 3..15).

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle load strobe; captures key_lo/key_hi.
- key_lo  input  128  K[NUM_KEYS-2]; word 0 = bits 127:96.
- key_hi  input  128  K[NUM_KEYS-1]; same packing.
- key_out  output  128  current round key; word 0 = bits 127:96.
- key_idx  output  4  index of key_out.
- key_valid  output  1  key_out/key_idx valid.
- key_ready  input  1  consumer accepts when key_valid & key_ready.
- key_last  output  1  high with key_valid when key_idx==0.

Behaviour:
- Reset (reset==1 at a clk edge): FSM=IDLE; key_valid=0, key_last=0, key_idx=0, key_out=0, window cleared. Reset overrides load.
- Internal state:
  - window W[0..7] of 32-bit words holding K[r] (W0..3) and K[r+1] (W4..7).
  - 4-bit r.
  - 4-bit idx.
- FSM states:
  - IDLE: key_valid=0. On load → EMIT with W0..3=key_lo, W4..7=key_hi, r=NUM_KEYS-2, idx=NUM_KEYS-1. key_valid goes high the cycle after load.
  - EMIT: key_valid=1.
    - key_out = W4..7 when idx==r+1, else W0..3.
    - key_idx = idx; key_last = (idx==0).
    - Outputs hold stable while key_ready=0.
- Accept in EMIT (key_valid & key_ready):
  - idx==r+1 → idx=r, no window change.
  - idx==r and r>=1 → backward step; r=r-1, idx=r-1.
  - idx==0 → FSM=IDLE, key_valid=0 the next cycle.
- Backward step, with C = current window:
  - new W4..7 = C0..3.
  - new W(j) = C(4+j) ^ C(3+j) for j=1..3.
  - new W0 = C4 ^ f(C3).
  - f uses forward step number s = r-1 (r before decrement):
    - s even: f(x) = SubWord(RotWord(x)) ^ {RCON(s/2), 24'h0}.
    - s odd: f(x) = SubWord(x).
  - RotWord: bytes [b0 b1 b2 b3] → [b1 b2 b3 b0], b0 = MSB.
  - SubWord applies the AES forward S-box per byte.
  - RCON(i) = 01,02,04,08,10,20,40,80,1B,36.
- Step is combinational from registered W; single cycle.
- Throughput: one key per clk with key_ready held high.
- Total handshakes per load: NUM_KEYS.
- load while in EMIT: aborts the current sequence and reloads; next cycle presents K[NUM_KEYS-1] from the new inputs. Load has priority over a simultaneous accept.
- load with reset high: ignored.
- key_ready while key_valid=0: ignored.
- No output is combinationally dependent on key_ready.

Test Plan:
- AES-256 key 000102…1f, NUM_KEYS=4, load key_lo=a573c29fa176c498a97fce93a572c09c, key_hi=1651a8cd0244beda1a5da4c10640bade, key_ready=1 → four consecutive cycles:
  - idx 3: 1651a8cd…0640bade
  - idx 2: a573c29f…a572c09c
  - idx 1: 101112131415161718191a1b1c1d1e1f
  - idx 0: 000102030405060708090a0b0c0d0e0f, with key_last=1
  - then key_valid=0.
- Same stimulus with key_ready toggled pseudo-randomly (stall up to 5 cycles) → identical key/idx sequence; key_out stable during every stall.
- NUM_KEYS=10: schedule from the forward expander on a random 256-bit key; load K8/K9 → outputs equal K9..K0 exactly; covers both odd and even s and RCON(0..3).
- Load during EMIT at idx 2 with a new key pair → next cycle key_idx=NUM_KEYS-1 with new key_hi; no stale keys emitted.
- reset asserted mid-sequence (with simultaneous load) → next cycle key_valid=0, key_out=0, key_idx=0; subsequent load restarts correctly.
- key_ready=1 held in IDLE with no load → key_valid stays 0 and no state change.
